// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle RV32I control FSM driving datapath enables and selects
module cpu_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zf,
  output logic             pc_write,
  output logic             pc0_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic [3:0]       alu_op,
  output logic             rs2_imm_s,
  output logic [1:0]       w_data_s,
  output logic [1:0]       pc_s,
  output logic [3:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXE_R   = 4'd3,
    S_EXE_I   = 4'd4,
    S_WB_ALU  = 4'd5,
    S_MEM_ADR = 4'd6,
    S_LD_RD   = 4'd7,
    S_LD_WB   = 4'd8,
    S_ST      = 4'd9,
    S_BEQ     = 4'd10,
    S_BR_DEC  = 4'd11,
    S_JAL     = 4'd12,
    S_JALR    = 4'd13,
    S_LUI     = 4'd14,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  state_t     cur, nxt;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       f75_q;
  logic       terminal;

  // Every terminal state hands back to FETCH, so being in one means the instruction retires on this edge.
  always_comb begin
    terminal = 1'b0;
    case (cur)
      S_WB_ALU, S_LD_WB, S_ST, S_BR_DEC, S_JAL, S_JALR, S_LUI: terminal = 1'b1;
      default: terminal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= S_IDLE;
      retire    <= 1'b0;
      illegal   <= 1'b0;
      instr_cnt <= '0;
      op_q      <= '0;
      f3_q      <= '0;
      f75_q     <= 1'b0;
    end else begin
      cur    <= nxt;
      retire <= terminal;
      if (terminal)
        instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (cur == S_DECODE) begin
        op_q  <= opcode;
        f3_q  <= funct3;
        f75_q <= funct7_5;
        if (nxt == S_HALT)
          illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt       = cur;
    pc_write  = 1'b0;
    pc0_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    alu_op    = ALU_ADD;
    rs2_imm_s = 1'b0;
    w_data_s  = 2'b00;
    pc_s      = 2'b00;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        pc0_write = 1'b1;
        nxt       = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              nxt = S_EXE_R;
          OP_I:              nxt = S_EXE_I;
          OP_LOAD, OP_STORE: nxt = S_MEM_ADR;
          OP_BR:             nxt = S_BEQ;
          OP_JAL:            nxt = S_JAL;
          OP_JALR:           nxt = S_JALR;
          OP_LUI:            nxt = S_LUI;
          default:           nxt = S_HALT;
        endcase
      end
      S_EXE_R: begin
        alu_op = {f75_q, f3_q};
        nxt    = S_WB_ALU;
      end
      S_EXE_I: begin
        // Only SRAI carries the arithmetic bit; for other I-types IR[30] is immediate data.
        rs2_imm_s = 1'b1;
        alu_op    = {f75_q & (f3_q == 3'b101), f3_q};
        nxt       = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEM_ADR: begin
        rs2_imm_s = 1'b1;
        nxt       = (op_q == OP_STORE) ? S_ST : S_LD_RD;
      end
      S_LD_RD: nxt = S_LD_WB;
      S_LD_WB: begin
        reg_write = 1'b1;
        w_data_s  = 2'b10;
        nxt       = S_FETCH;
      end
      S_ST: begin
        mem_write = 1'b1;
        nxt       = S_FETCH;
      end
      S_BEQ: begin
        alu_op = ALU_SUB;
        nxt    = S_BR_DEC;
      end
      S_BR_DEC: begin
        pc_write = zf;
        pc_s     = zf ? 2'b01 : 2'b00;
        nxt      = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1;
        w_data_s  = 2'b11;
        pc_write  = 1'b1;
        pc_s      = 2'b01;
        nxt       = S_FETCH;
      end
      S_JALR: begin
        rs2_imm_s = 1'b1;
        reg_write = 1'b1;
        w_data_s  = 2'b11;
        pc_write  = 1'b1;
        pc_s      = 2'b10;
        nxt       = S_FETCH;
      end
      S_LUI: begin
        reg_write = 1'b1;
        w_data_s  = 2'b01;
        nxt       = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  assign state = cur;

endmodule
